// File: rtl/accum5.sv
// accum5: 4-bit registered ALU; result and flag load one cycle after inputs are sampled.
// No handshake or backpressure: every rising edge loads, except reserved modes, which hold the current value.
module accum5 (
    input  logic       Clk,
    input  logic       nReset,
    output logic [3:0] r,
    output logic       of,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [3:0] m
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_CMP  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_INC  = 4'b0110,
        OP_DEC  = 4'b0111,
        OP_SHL0 = 4'b1000,
        OP_SHL1 = 4'b1001,
        OP_SHR0 = 4'b1010,
        OP_SHR1 = 4'b1011
    } op_e;

    logic [3:0] r_q, r_d;
    logic       of_q, of_d;
    logic [4:0] sum5;
    logic [4:0] diff5;
    logic [4:0] inc5;
    logic [4:0] dec5;

    assign sum5  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // The difference spans -16..15, so bit 4 of the 5-bit result is exactly the borrow.
    assign diff5 = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
    assign inc5  = {1'b0, a} + 5'd1;
    assign dec5  = {1'b0, a} - 5'd1;

    always_comb begin
        r_d  = r_q;
        of_d = of_q;
        case (m)
            OP_ADD:  begin r_d = sum5[3:0];  of_d = sum5[4];  end
            OP_SUB:  begin r_d = diff5[3:0]; of_d = diff5[4]; end
            OP_CMP:  begin r_d = {1'b0, a > b, a == b, a < b}; of_d = 1'b0; end
            OP_AND:  begin r_d = a & b; of_d = 1'b0; end
            OP_OR:   begin r_d = a | b; of_d = 1'b0; end
            OP_NOT:  begin r_d = ~a;    of_d = 1'b0; end
            OP_INC:  begin r_d = inc5[3:0]; of_d = inc5[4]; end
            OP_DEC:  begin r_d = dec5[3:0]; of_d = dec5[4]; end
            OP_SHL0: begin r_d = {a[2:0], 1'b0}; of_d = a[3]; end
            OP_SHL1: begin r_d = {a[2:0], 1'b1}; of_d = a[3]; end
            OP_SHR0: begin r_d = {1'b0, a[3:1]}; of_d = a[0]; end
            OP_SHR1: begin r_d = {1'b1, a[3:1]}; of_d = a[0]; end
            default: begin r_d = r_q; of_d = of_q; end
        endcase
    end

    always_ff @(posedge Clk or posedge nReset) begin
        if (nReset) begin
            r_q  <= 4'b0000;
            of_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            of_q <= of_d;
        end
    end

    assign r  = r_q;
    assign of = of_q;

endmodule

// File: tb/tb_accum5.sv
// Bench for accum5: arithmetic reference model checked every cycle, plus literal directed vectors.
module tb_accum5;

    logic       Clk;
    logic       nReset;
    logic [3:0] r;
    logic       of;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] m;

    int checks;
    int fails;
    bit chk_en;

    logic [3:0] m_r;
    logic       m_of;

    accum5 dut (
        .Clk    (Clk),
        .nReset (nReset),
        .r      (r),
        .of     (of),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .m      (m)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: each op expressed as integer arithmetic on the operand values.
    function automatic logic [4:0] ref_f(input logic [3:0] fa, input logic [3:0] fb,
                                         input logic fc, input logic [3:0] fm,
                                         input logic [4:0] cur);
        int ia, ib, ic, t, rr, oo;
        ia = int'(fa);
        ib = int'(fb);
        ic = fc ? 1 : 0;
        rr = int'(cur[3:0]);
        oo = cur[4] ? 1 : 0;
        case (int'(fm))
            0:  begin t = ia + ib + ic; rr = t % 16; oo = (t > 15) ? 1 : 0; end
            1:  begin t = ia - ib - ic; rr = (t + 32) % 16; oo = (ia < ib + ic) ? 1 : 0; end
            2:  begin rr = (ia > ib ? 4 : 0) + (ia == ib ? 2 : 0) + (ia < ib ? 1 : 0); oo = 0; end
            3:  begin rr = int'(fa & fb); oo = 0; end
            4:  begin rr = int'(fa | fb); oo = 0; end
            5:  begin rr = 15 - ia; oo = 0; end
            6:  begin rr = (ia + 1) % 16; oo = (ia == 15) ? 1 : 0; end
            7:  begin rr = (ia + 15) % 16; oo = (ia == 0) ? 1 : 0; end
            8:  begin rr = (ia * 2) % 16;     oo = ia / 8; end
            9:  begin rr = (ia * 2) % 16 + 1; oo = ia / 8; end
            10: begin rr = ia / 2;            oo = ia % 2; end
            11: begin rr = ia / 2 + 8;        oo = ia % 2; end
            default: ;
        endcase
        return {oo[0], rr[3:0]};
    endfunction

    always @(posedge Clk or posedge nReset) begin
        if (nReset) begin
            m_r  <= 4'b0000;
            m_of <= 1'b0;
        end else begin
            {m_of, m_r} <= ref_f(a, b, cin, m, {m_of, m_r});
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            checks++;
            if (r !== m_r || of !== m_of) begin
                fails++;
                $display("FAIL model t=%0t m=%b a=%b b=%b cin=%b: got r=%b of=%b, want r=%b of=%b",
                         $time, m, a, b, cin, r, of, m_r, m_of);
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] er, input logic eo);
        checks++;
        if (r !== er || of !== eo) begin
            fails++;
            $display("FAIL %s: got r=%b of=%b, want r=%b of=%b", nm, r, of, er, eo);
        end
    endtask

    task automatic dir(input string nm, input logic [3:0] vm, input logic [3:0] va,
                       input logic [3:0] vb, input logic vc,
                       input logic [3:0] er, input logic eo);
        @(negedge Clk);
        m = vm; a = va; b = vb; cin = vc;
        @(posedge Clk);
        #1;
        chk(nm, er, eo);
    endtask

    initial begin
        nReset = 1'b1;
        a = 4'b0000; b = 4'b0000; cin = 1'b0; m = 4'b0000;
        checks = 0;
        fails = 0;
        chk_en = 1'b0;
        #1;
        chk("reset_t0", 4'b0000, 1'b0);
        chk_en = 1'b1;

        // Held in reset across edges with a live op selected.
        @(negedge Clk);
        m = 4'b0000; a = 4'b1111; b = 4'b0001; cin = 1'b0;
        @(posedge Clk); #1;
        chk("reset_held", 4'b0000, 1'b0);
        @(negedge Clk);
        nReset = 1'b0;
        @(posedge Clk); #1;
        chk("add_first_after_release", 4'b0000, 1'b1);

        dir("add_1010_0101", 4'b0000, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0);
        dir("add_0111_1100", 4'b0000, 4'b0111, 4'b1100, 1'b0, 4'b0011, 1'b1);
        dir("add_cin",       4'b0000, 4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1);
        dir("sub_1111_1001", 4'b0001, 4'b1111, 4'b1001, 1'b0, 4'b0110, 1'b0);
        dir("sub_0111_1100", 4'b0001, 4'b0111, 4'b1100, 1'b0, 4'b1011, 1'b1);
        dir("sub_cin_borrow",4'b0001, 4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1);
        dir("cmp_gt",        4'b0010, 4'b1001, 4'b0001, 1'b0, 4'b0100, 1'b0);
        dir("cmp_lt",        4'b0010, 4'b0111, 4'b1100, 1'b1, 4'b0001, 1'b0);
        dir("cmp_eq",        4'b0010, 4'b0110, 4'b0110, 1'b0, 4'b0010, 1'b0);
        dir("and",           4'b0011, 4'b1010, 4'b0101, 1'b0, 4'b0000, 1'b0);
        dir("or",            4'b0100, 4'b0111, 4'b1100, 1'b0, 4'b1111, 1'b0);
        dir("not",           4'b0101, 4'b1001, 4'b1111, 1'b1, 4'b0110, 1'b0);
        dir("inc",           4'b0110, 4'b1001, 4'b0000, 1'b0, 4'b1010, 1'b0);
        dir("dec",           4'b0111, 4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b0);
        dir("inc_wrap",      4'b0110, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1);
        dir("dec_wrap",      4'b0111, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b1);
        dir("shl0",          4'b1000, 4'b1111, 4'b0000, 1'b0, 4'b1110, 1'b1);
        dir("shl1",          4'b1001, 4'b1010, 4'b0000, 1'b0, 4'b0101, 1'b1);
        dir("shr0",          4'b1010, 4'b1001, 4'b0000, 1'b0, 4'b0100, 1'b1);
        dir("shr1",          4'b1011, 4'b0111, 4'b0000, 1'b0, 4'b1011, 1'b1);
        dir("rsv_1100_hold", 4'b1100, 4'b0000, 4'b1111, 1'b1, 4'b1011, 1'b1);
        dir("rsv_1111_hold", 4'b1111, 4'b0101, 4'b0011, 1'b0, 4'b1011, 1'b1);

        // Asynchronous reset mid-cycle, away from any clock edge.
        @(negedge Clk);
        m = 4'b0110; a = 4'b0011;
        #1 nReset = 1'b1;
        #1 chk("async_reset_no_clock", 4'b0000, 1'b0);
        #1 nReset = 1'b0;
        @(posedge Clk); #1;
        chk("first_edge_after_async", 4'b0100, 1'b0);

        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            m   = 4'($urandom_range(0, 15));
            a   = 4'($urandom);
            b   = 4'($urandom);
            cin = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1 nReset = 1'b1;
                #1 chk("rand_async_reset", 4'b0000, 1'b0);
                #1 nReset = 1'b0;
            end
        end

        @(negedge Clk);
        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
